// File: rtl/voice_pwm_mixer_pkg.sv
// Shared constants and helpers for the voice PWM mixer.
// Voice control word layout: bit 15 enables the voice, bits 14:0 hold the half-period in ticks.
package voice_pwm_mixer_pkg;

  localparam int unsigned NUM_VOICES    = 8;
  localparam int unsigned VOICE_EN_BIT  = 15;
  localparam int unsigned HALF_PERIOD_W = 15;
  localparam int unsigned MIX_W         = 4;

  function automatic logic [MIX_W-1:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [MIX_W-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      sum = sum + MIX_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/voice_pwm_mixer_voice_osc.sv
// Single square-wave voice: a tick-driven down-counter that toggles the phase at each reload.
// A disabled voice, or one with a zero half-period, is held at counter 0 and phase 0.
module voice_osc
  import voice_pwm_mixer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [15:0] ctrl,
  output logic        wave
);

  logic [HALF_PERIOD_W-1:0] cnt_q, cnt_d;
  logic                     phase_q, phase_d;
  logic                     active;

  always_comb begin
    active  = ctrl[VOICE_EN_BIT] && (ctrl[HALF_PERIOD_W-1:0] != '0);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!active) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (cnt_q == '0) begin
        // Half-period is sampled only here, so edits never cut a half-period short.
        phase_d = ~phase_q;
        cnt_d   = ctrl[HALF_PERIOD_W-1:0] - HALF_PERIOD_W'(1);
      end else begin
        cnt_d = cnt_q - HALF_PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign wave = phase_q;

endmodule

// File: rtl/voice_pwm_mixer.sv
// Eight-voice square-wave generator mixed into a single PWM audio stream.
// A shared prescaler paces the voices; the number of high voices sets the duty of each 8-clk frame.
module voice_pwm_mixer
  import voice_pwm_mixer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           pwm_reg0,
  input  logic [15:0]           pwm_reg1,
  input  logic [15:0]           pwm_reg2,
  input  logic [15:0]           pwm_reg3,
  input  logic [15:0]           pwm_reg4,
  input  logic [15:0]           pwm_reg5,
  input  logic [15:0]           pwm_reg6,
  input  logic [15:0]           pwm_reg7,
  output logic [NUM_VOICES-1:0] voice_out,
  output logic [MIX_W-1:0]      mix_level,
  output logic                  audio_pwm,
  output logic                  tick
);

  localparam int unsigned FrameW  = $clog2(FRAME_LEN);
  localparam logic [15:0] PreLast = 16'(PRESCALE - 1);

  logic [15:0]        presc_q, presc_d;
  logic               tick_q, tick_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic [MIX_W-1:0]   mix_q, mix_d;
  logic               audio_q, audio_d;
  logic [15:0]        ctrl [NUM_VOICES];

  assign ctrl[0] = pwm_reg0;
  assign ctrl[1] = pwm_reg1;
  assign ctrl[2] = pwm_reg2;
  assign ctrl[3] = pwm_reg3;
  assign ctrl[4] = pwm_reg4;
  assign ctrl[5] = pwm_reg5;
  assign ctrl[6] = pwm_reg6;
  assign ctrl[7] = pwm_reg7;

  // tick is registered from the next count so it is high exactly while presc_q == PreLast.
  always_comb begin
    presc_d = (presc_q == PreLast) ? '0 : presc_q + 16'd1;
    tick_d  = (presc_d == PreLast);
    frame_d = frame_q + FrameW'(1);
    mix_d   = (frame_q == '0) ? popcount(voice_out) : mix_q;
    audio_d = (MIX_W'(frame_q) < mix_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      frame_q <= '0;
      mix_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      mix_q   <= mix_d;
      audio_q <= audio_d;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_osc u_osc (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_q),
      .ctrl (ctrl[i]),
      .wave (voice_out[i])
    );
  end

  assign tick      = tick_q;
  assign mix_level = mix_q;
  assign audio_pwm = audio_q;

endmodule

// File: tb/tb_voice_pwm_mixer.sv
// Randomised and directed bench for voice_pwm_mixer, checked every cycle against a
// behavioural model of the prescaler, voices, frame sampler and PWM comparator.
module tb_voice_pwm_mixer;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] regs [8];
  logic [7:0]  voice_out;
  logic [3:0]  mix_level;
  logic        audio_pwm;
  logic        tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int pc;
  int vcnt [8];
  int vph  [8];
  int frame;
  int mix;
  int audio;

  always #5 clk = ~clk;

  voice_pwm_mixer #(
    .PRESCALE  (P),
    .FRAME_LEN (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_reg0  (regs[0]),
    .pwm_reg1  (regs[1]),
    .pwm_reg2  (regs[2]),
    .pwm_reg3  (regs[3]),
    .pwm_reg4  (regs[4]),
    .pwm_reg5  (regs[5]),
    .pwm_reg6  (regs[6]),
    .pwm_reg7  (regs[7]),
    .voice_out (voice_out),
    .mix_level (mix_level),
    .audio_pwm (audio_pwm),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented before the edge.
  function automatic void model_step();
    int tk;
    int ones;
    int hp;
    if (rst) begin
      pc = 0; frame = 0; mix = 0; audio = 0;
      for (int i = 0; i < 8; i++) begin
        vcnt[i] = 0;
        vph[i]  = 0;
      end
      return;
    end
    tk   = (pc == P - 1) ? 1 : 0;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += vph[i];
    audio = (frame < mix) ? 1 : 0;
    if (frame == 0) mix = ones;
    frame = (frame + 1) % 8;
    for (int i = 0; i < 8; i++) begin
      hp = int'(regs[i][14:0]);
      if (!(regs[i][15] && hp != 0)) begin
        vcnt[i] = 0;
        vph[i]  = 0;
      end else if (tk == 1) begin
        if (vcnt[i] == 0) begin
          vph[i]  = 1 - vph[i];
          vcnt[i] = hp - 1;
        end else begin
          vcnt[i] = vcnt[i] - 1;
        end
      end
    end
    pc = (pc + 1) % P;
  endfunction

  function automatic logic [7:0] model_voices();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (vph[i] != 0);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("voice_out", 32'(voice_out), 32'(model_voices()));
    check("mix_level", 32'(mix_level), 32'(mix));
    check("audio_pwm", 32'(audio_pwm), 32'(audio));
    check("tick", 32'(tick), 32'((pc == P - 1) ? 1 : 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until voice_out[idx] changes; gives up after 64 steps.
  task automatic wait_toggle(input int idx, output int n);
    logic prev;
    prev = voice_out[idx];
    n = 0;
    while (voice_out[idx] == prev && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
  endtask

  initial begin
    int n;
    int highs;
    int ok;

    rst = 1'b1;
    clear_regs();
    run(3);
    rst = 1'b0;
    run(4);

    // Voice 0, half-period 3 ticks: 6-clk half-periods, other voices silent.
    regs[0] = 16'h8003;
    wait_toggle(0, n);
    wait_toggle(0, n);
    check("v0_half_period", 32'(n), 32'd6);
    wait_toggle(0, n);
    check("v0_half_period2", 32'(n), 32'd6);
    check("v0_others_low", 32'(voice_out[7:1]), 32'd0);
    run(10);

    // Enable bit clear, or zero half-period: voice stays low.
    regs[0] = 16'h0000;
    regs[1] = 16'h0005;
    run(20);
    check("v1_disabled", 32'(voice_out[1]), 32'd0);
    regs[1] = 16'h8000;
    run(20);
    check("v1_zero_period", 32'(voice_out[1]), 32'd0);
    regs[1] = 16'h0000;

    // Half-period change mid-count completes the current half first.
    regs[2] = 16'h8004;
    wait_toggle(2, n);
    wait_toggle(2, n);
    run(2);
    regs[2] = 16'h8001;
    wait_toggle(2, n);
    check("v2_old_half", 32'(n + 2), 32'd8);
    wait_toggle(2, n);
    check("v2_new_half", 32'(n), 32'd2);
    regs[2] = 16'h0000;
    run(2);

    // All voices at half-period 1, enabled together so they stay phase-aligned.
    for (int i = 0; i < 8; i++) regs[i] = 16'h8001;
    run(40);
    ok = (mix_level == 4'd0 || mix_level == 4'd8) ? 1 : 0;
    check("all_mix_extreme", 32'(ok), 32'd1);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      highs += int'(audio_pwm);
    end
    check("all_duty", 32'(highs), (mix_level == 4'd8) ? 32'd8 : 32'd0);

    // Three long-period voices go high and stay high across several frames.
    clear_regs();
    run(2);
    for (int i = 0; i < 3; i++) regs[i] = 16'hFFFF;
    run(24);
    check("three_mix", 32'(mix_level), 32'd3);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      highs += int'(audio_pwm);
    end
    check("three_duty", 32'(highs), 32'd3);

    // One-clk reset pulse mid-tone.
    regs[3] = 16'h8003;
    regs[4] = 16'h8002;
    run(15);
    rst = 1'b1;
    step();
    check("rst_voice_out", 32'(voice_out), 32'd0);
    check("rst_mix", 32'(mix_level), 32'd0);
    check("rst_audio", 32'(audio_pwm), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    n = 1;
    while (tick == 1'b0 && n < 16) begin
      step();
      n++;
    end
    check("tick_after_rst", 32'(n), 32'(P));

    // Random register traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        int v;
        v = $urandom_range(0, 7);
        case ($urandom_range(0, 3))
          0: regs[v] = 16'($urandom);
          1: regs[v] = 16'h0000 | 16'($urandom_range(0, 6));
          default: regs[v] = 16'h8000 | 16'($urandom_range(0, 6));
        endcase
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
